// File: rtl/ev22_pkg.sv
// Shared EV22 register-bank definitions: select/data widths, scratch slot and write request type.
package ev22_pkg;

    localparam int unsigned REG_SEL_W     = 6;
    localparam int unsigned DATA_W        = 16;
    localparam int unsigned NUM_ARCH_REGS = 32;
    localparam int unsigned ARCH_IDX_W    = $clog2(NUM_ARCH_REGS);

    localparam logic [REG_SEL_W-1:0] SCRATCH_SEL = 6'd34;

    typedef struct packed {
        logic [REG_SEL_W-1:0] sel;
        logic [DATA_W-1:0]    data;
    } wb_req_t;

    function automatic logic is_arch_sel(input logic [REG_SEL_W-1:0] sel);
        return sel < REG_SEL_W'(NUM_ARCH_REGS);
    endfunction

endpackage

// File: rtl/regfile_writeback_fifo.sv
// wb_fifo: synchronous FIFO of write-back requests; pointers carry one extra wrap bit.
module wb_fifo
    import ev22_pkg::*;
#(
    parameter int unsigned DEPTH = 4
) (
    input  logic    clk,
    input  logic    nreset,
    input  logic    push,
    input  wb_req_t push_req,
    input  logic    pop,
    output logic    full,
    output logic    empty,
    output wb_req_t head
);

    localparam int unsigned IDX_W = $clog2(DEPTH);
    localparam int unsigned PTR_W = IDX_W + 1;

    logic [PTR_W-1:0] wr_ptr_q, wr_ptr_d;
    logic [PTR_W-1:0] rd_ptr_q, rd_ptr_d;
    wb_req_t          mem_q [DEPTH];
    wb_req_t          mem_d [DEPTH];

    // Same index with differing wrap bits means the writer is a full lap ahead.
    always_comb begin
        full  = (wr_ptr_q[PTR_W-1] != rd_ptr_q[PTR_W-1]) &&
                (wr_ptr_q[IDX_W-1:0] == rd_ptr_q[IDX_W-1:0]);
        empty = (wr_ptr_q == rd_ptr_q);
        head  = mem_q[rd_ptr_q[IDX_W-1:0]];
    end

    always_comb begin
        mem_d    = mem_q;
        wr_ptr_d = wr_ptr_q;
        rd_ptr_d = rd_ptr_q;
        if (push && !full) begin
            mem_d[wr_ptr_q[IDX_W-1:0]] = push_req;
            wr_ptr_d                   = wr_ptr_q + PTR_W'(1);
        end
        if (pop && !empty) begin
            rd_ptr_d = rd_ptr_q + PTR_W'(1);
        end
    end

    always_ff @(posedge clk or negedge nreset) begin
        if (!nreset) begin
            wr_ptr_q <= '0;
            rd_ptr_q <= '0;
            for (int unsigned i = 0; i < DEPTH; i++) begin
                mem_q[i] <= '0;
            end
        end else begin
            wr_ptr_q <= wr_ptr_d;
            rd_ptr_q <= rd_ptr_d;
            mem_q    <= mem_d;
        end
    end

endmodule

// File: rtl/regfile_writeback.sv
// Write-back sequencer for the EV22 bank write port: load FIFO, ALU/load arbitration, pending scoreboard.
// Optional WB_BYPASS_EN adds combinational forwarding of the value currently on Sel_C/Data_C.
module regfile_writeback
    import ev22_pkg::*;
#(
    parameter int unsigned          LOAD_DEPTH = 4,
    parameter logic [REG_SEL_W-1:0] IDLE_SEL   = SCRATCH_SEL
) (
    input  logic                     clk,
    input  logic                     nreset,
    input  logic                     alu_valid,
    input  logic [REG_SEL_W-1:0]     alu_sel,
    input  logic [DATA_W-1:0]        alu_data,
    output logic                     alu_ready,
    input  logic                     mem_valid,
    input  logic [REG_SEL_W-1:0]     mem_sel,
    input  logic [DATA_W-1:0]        mem_data,
    output logic                     mem_ready,
    input  logic                     issue_valid,
    input  logic [REG_SEL_W-1:0]     issue_sel,
    output logic [NUM_ARCH_REGS-1:0] pending,
    output logic [REG_SEL_W-1:0]     Sel_C,
    output logic [DATA_W-1:0]        Data_C
`ifdef WB_BYPASS_EN
    ,
    input  logic [4:0]               rd_sel_a,
    input  logic [REG_SEL_W-1:0]     rd_sel_b,
    output logic                     fwd_a_hit,
    output logic                     fwd_b_hit,
    output logic [DATA_W-1:0]        fwd_data
`endif
);

    logic    fifo_full, fifo_empty;
    logic    fifo_push, fifo_pop;
    logic    grant_alu, grant_fifo;
    wb_req_t fifo_head, mem_req, win_req;

    logic [REG_SEL_W-1:0]     sel_c_q, sel_c_d;
    logic [DATA_W-1:0]        data_c_q, data_c_d;
    logic [NUM_ARCH_REGS-1:0] pending_q, pending_d;

    assign mem_req = '{sel: mem_sel, data: mem_data};

    wb_fifo #(
        .DEPTH (LOAD_DEPTH)
    ) u_load_fifo (
        .clk      (clk),
        .nreset   (nreset),
        .push     (fifo_push),
        .push_req (mem_req),
        .pop      (fifo_pop),
        .full     (fifo_full),
        .empty    (fifo_empty),
        .head     (fifo_head)
    );

    // A full FIFO pre-empts the ALU so loads can never be starved indefinitely.
    always_comb begin
        grant_fifo = fifo_full || (!alu_valid && !fifo_empty);
        grant_alu  = alu_valid && !fifo_full;
        alu_ready  = grant_alu;
        mem_ready  = !fifo_full;
        fifo_push  = mem_valid && !fifo_full;
        fifo_pop   = grant_fifo;

        win_req = '{sel: IDLE_SEL, data: '0};
        if (grant_fifo) begin
            win_req = fifo_head;
        end else if (grant_alu) begin
            win_req = '{sel: alu_sel, data: alu_data};
        end
        sel_c_d  = win_req.sel;
        data_c_d = win_req.data;
    end

    // Clear first, then set, so an issue on the retiring edge keeps the bit.
    always_comb begin
        pending_d = pending_q;
        if ((grant_fifo || grant_alu) && is_arch_sel(win_req.sel)) begin
            pending_d[win_req.sel[ARCH_IDX_W-1:0]] = 1'b0;
        end
        if (issue_valid && is_arch_sel(issue_sel)) begin
            pending_d[issue_sel[ARCH_IDX_W-1:0]] = 1'b1;
        end
    end

    always_ff @(posedge clk or negedge nreset) begin
        if (!nreset) begin
            sel_c_q   <= IDLE_SEL;
            data_c_q  <= '0;
            pending_q <= '0;
        end else begin
            sel_c_q   <= sel_c_d;
            data_c_q  <= data_c_d;
            pending_q <= pending_d;
        end
    end

    assign Sel_C   = sel_c_q;
    assign Data_C  = data_c_q;
    assign pending = pending_q;

`ifdef WB_BYPASS_EN
    always_comb begin
        fwd_a_hit = ({1'b0, rd_sel_a} == sel_c_q) && (sel_c_q != IDLE_SEL);
        fwd_b_hit = (rd_sel_b == sel_c_q) && (sel_c_q != IDLE_SEL);
        fwd_data  = data_c_q;
    end
`endif

endmodule

// File: tb/tb_regfile_writeback.sv
// Bench for regfile_writeback: queue-based reference model, directed scenarios, randomized traffic.
module tb_regfile_writeback;

    localparam int unsigned LD   = 4;
    localparam logic [5:0]  IDLE = 6'd34;

    logic        clk, nreset;
    logic        alu_valid, mem_valid, issue_valid;
    logic [5:0]  alu_sel, mem_sel, issue_sel;
    logic [15:0] alu_data, mem_data;
    logic        alu_ready, mem_ready;
    logic [31:0] pending;
    logic [5:0]  Sel_C;
    logic [15:0] Data_C;
`ifdef WB_BYPASS_EN
    logic [4:0]  rd_sel_a;
    logic [5:0]  rd_sel_b;
    logic        fwd_a_hit, fwd_b_hit;
    logic [15:0] fwd_data;
    logic [4:0]  rd_a_val;
    logic [5:0]  rd_b_val;
`endif

    regfile_writeback #(
        .LOAD_DEPTH (LD),
        .IDLE_SEL   (IDLE)
    ) dut (
        .clk         (clk),
        .nreset      (nreset),
        .alu_valid   (alu_valid),
        .alu_sel     (alu_sel),
        .alu_data    (alu_data),
        .alu_ready   (alu_ready),
        .mem_valid   (mem_valid),
        .mem_sel     (mem_sel),
        .mem_data    (mem_data),
        .mem_ready   (mem_ready),
        .issue_valid (issue_valid),
        .issue_sel   (issue_sel),
        .pending     (pending),
        .Sel_C       (Sel_C),
        .Data_C      (Data_C)
`ifdef WB_BYPASS_EN
        ,
        .rd_sel_a    (rd_sel_a),
        .rd_sel_b    (rd_sel_b),
        .fwd_a_hit   (fwd_a_hit),
        .fwd_b_hit   (fwd_b_hit),
        .fwd_data    (fwd_data)
`endif
    );

    initial clk = 1'b0;
    always #5 clk = ~clk;

    typedef struct packed {
        bit [5:0]  sel;
        bit [15:0] data;
    } ent_t;

    ent_t      q[$];
    bit [5:0]  m_sel;
    bit [15:0] m_data;
    bit [31:0] m_pend;
    bit        last_acc;
    int        n_cmp, n_fail;

    task automatic chk(input string nm, input logic [31:0] act, input logic [31:0] exp);
        n_cmp++;
        if (act !== exp) begin
            n_fail++;
            $display("FAIL %s: got %0h expected %0h at %0t", nm, act, exp, $time);
        end
    endtask

    task automatic model_reset();
        q.delete();
        m_sel    = IDLE;
        m_data   = 16'h0;
        m_pend   = 32'h0;
        last_acc = 1'b0;
    endtask

    // Drive one cycle's inputs, check the combinational outputs, advance the model past the coming edge.
    task automatic drive(input bit av, input bit [5:0] as, input bit [15:0] ad,
                         input bit mv, input bit [5:0] ms, input bit [15:0] md,
                         input bit iv, input bit [5:0] isel);
        bit   full, granted;
        ent_t w;
        @(negedge clk);
        alu_valid = av;  alu_sel = as;  alu_data = ad;
        mem_valid = mv;  mem_sel = ms;  mem_data = md;
        issue_valid = iv; issue_sel = isel;
`ifdef WB_BYPASS_EN
        rd_sel_a = rd_a_val;
        rd_sel_b = rd_b_val;
`endif
        #1;
        full = (q.size() >= LD);
        chk("mem_ready", 32'(mem_ready), 32'(!full));
        chk("alu_ready", 32'(alu_ready), 32'(av && !full));
`ifdef WB_BYPASS_EN
        chk("fwd_a_hit", 32'(fwd_a_hit), 32'(({1'b0, rd_a_val} == m_sel) && (m_sel != IDLE)));
        chk("fwd_b_hit", 32'(fwd_b_hit), 32'((rd_b_val == m_sel) && (m_sel != IDLE)));
        chk("fwd_data", 32'(fwd_data), 32'(m_data));
`endif
        last_acc = av && !full;
        granted  = 1'b1;
        w        = '0;
        if (full || (!av && q.size() > 0)) w = q.pop_front();
        else if (av) w = '{sel: as, data: ad};
        else granted = 1'b0;
        if (mv && !full) q.push_back('{sel: ms, data: md});
        if (granted) begin
            m_sel  = w.sel;
            m_data = w.data;
            if (w.sel < 6'd32) m_pend[w.sel[4:0]] = 1'b0;
        end else begin
            m_sel  = IDLE;
            m_data = 16'h0;
        end
        if (iv && isel < 6'd32) m_pend[isel[4:0]] = 1'b1;
    endtask

    task automatic settle();
        @(posedge clk);
        #1;
        chk("Sel_C", 32'(Sel_C), 32'(m_sel));
        chk("Data_C", 32'(Data_C), 32'(m_data));
        chk("pending", pending, m_pend);
    endtask

    task automatic step(input bit av, input bit [5:0] as, input bit [15:0] ad,
                        input bit mv, input bit [5:0] ms, input bit [15:0] md,
                        input bit iv, input bit [5:0] isel);
        drive(av, as, ad, mv, ms, md, iv, isel);
        settle();
    endtask

    task automatic idle();
        step(0, 6'd0, 16'h0, 0, 6'd0, 16'h0, 0, 6'd0);
    endtask

    task automatic zero_inputs();
        alu_valid = 0; alu_sel = '0; alu_data = '0;
        mem_valid = 0; mem_sel = '0; mem_data = '0;
        issue_valid = 0; issue_sel = '0;
`ifdef WB_BYPASS_EN
        rd_a_val = '0; rd_b_val = '0;
        rd_sel_a = '0; rd_sel_b = '0;
`endif
    endtask

    bit        ra_v, rm_v, ri_v;
    bit [5:0]  ra_s, rm_s, ri_s;
    bit [15:0] ra_d, rm_d;

    initial begin
        n_cmp = 0;
        n_fail = 0;
        zero_inputs();
        model_reset();
        nreset = 1'b0;
        repeat (2) @(negedge clk);
        nreset = 1'b1;

        repeat (3) idle();
        chk("reset Sel_C", 32'(Sel_C), 32'd34);
        chk("reset Data_C", 32'(Data_C), 32'd0);
        chk("reset pending", pending, 32'd0);
        chk("reset mem_ready", 32'(mem_ready), 32'd1);

        // issue r5, then ALU retires it
        step(0, 6'd0, 16'h0, 0, 6'd0, 16'h0, 1, 6'd5);
        chk("issue r5 pending", pending, 32'h0000_0020);
        drive(1, 6'd5, 16'h1234, 0, 6'd0, 16'h0, 0, 6'd0);
        chk("alu r5 ready", 32'(alu_ready), 32'd1);
        settle();
        chk("alu r5 Sel_C", 32'(Sel_C), 32'd5);
        chk("alu r5 Data_C", 32'(Data_C), 32'h1234);
        chk("alu r5 pending", pending, 32'd0);

        // ALU and load together: ALU first, load next cycle
        drive(1, 6'd3, 16'hAAAA, 1, 6'd7, 16'h5555, 0, 6'd0);
        chk("dual alu_ready", 32'(alu_ready), 32'd1);
        settle();
        chk("dual first sel", 32'(Sel_C), 32'd3);
        chk("dual first data", 32'(Data_C), 32'hAAAA);
        idle();
        chk("dual second sel", 32'(Sel_C), 32'd7);
        chk("dual second data", 32'(Data_C), 32'h5555);

        // fill the FIFO while the ALU keeps winning
        for (int i = 0; i < 4; i++)
            step(1, 6'd12, 16'hC0DE, 1, 6'(8 + i), 16'(16'h0100 + i), 0, 6'd0);
        drive(1, 6'd12, 16'hC0DE, 0, 6'd0, 16'h0, 0, 6'd0);
        chk("full mem_ready", 32'(mem_ready), 32'd0);
        chk("full alu_ready", 32'(alu_ready), 32'd0);
        settle();
        chk("full head sel", 32'(Sel_C), 32'd8);
        chk("full head data", 32'(Data_C), 32'h0100);
        step(1, 6'd12, 16'hC0DE, 0, 6'd0, 16'h0, 0, 6'd0);
        chk("stalled alu sel", 32'(Sel_C), 32'd12);
        for (int i = 1; i < 4; i++) begin
            idle();
            chk("drain sel", 32'(Sel_C), 32'(8 + i));
            chk("drain data", 32'(Data_C), 32'(16'h0100 + i));
        end
        idle();

        // set wins over clear; non-architectural select leaves scoreboard alone
        step(1, 6'd2, 16'h2222, 0, 6'd0, 16'h0, 1, 6'd2);
        chk("set wins pending", pending, 32'h0000_0004);
        step(1, 6'd40, 16'h4040, 0, 6'd0, 16'h0, 0, 6'd0);
        chk("sel40 Sel_C", 32'(Sel_C), 32'd40);
        chk("sel40 pending", pending, 32'h0000_0004);
        step(1, 6'd2, 16'h2223, 0, 6'd0, 16'h0, 0, 6'd0);
        idle();

`ifdef WB_BYPASS_EN
        step(1, 6'd6, 16'hBEEF, 0, 6'd0, 16'h0, 0, 6'd0);
        rd_a_val = 5'd6;
        rd_sel_a = 5'd6;
        #1;
        chk("bypass hit", 32'(fwd_a_hit), 32'd1);
        chk("bypass data", 32'(fwd_data), 32'hBEEF);
        idle();
        #1;
        chk("bypass idle hit", 32'(fwd_a_hit), 32'd0);
`endif

        ra_v = 0; ra_s = '0; ra_d = '0;
        for (int c = 0; c < 1500; c++) begin
            if (c == 700) begin
                @(negedge clk);
                #2;
                nreset = 1'b0;
                #1;
                chk("midreset Sel_C", 32'(Sel_C), 32'd34);
                chk("midreset Data_C", 32'(Data_C), 32'd0);
                chk("midreset pending", pending, 32'd0);
                chk("midreset mem_ready", 32'(mem_ready), 32'd1);
                zero_inputs();
                model_reset();
                ra_v = 0;
                @(negedge clk);
                #1;
                nreset = 1'b1;
            end
            if (!(ra_v && !last_acc)) begin
                ra_v = ($urandom_range(0, 99) < 60);
                ra_s = 6'($urandom_range(0, 39));
                ra_d = 16'($urandom);
            end
            rm_v = ($urandom_range(0, 99) < 50);
            rm_s = 6'($urandom_range(0, 39));
            rm_d = 16'($urandom);
            ri_v = ($urandom_range(0, 99) < 30);
            ri_s = 6'($urandom_range(0, 39));
`ifdef WB_BYPASS_EN
            rd_a_val = $urandom_range(0, 1) ? m_sel[4:0] : 5'($urandom_range(0, 31));
            rd_b_val = $urandom_range(0, 1) ? m_sel : 6'($urandom_range(0, 39));
`endif
            step(ra_v, ra_s, ra_d, rm_v, rm_s, rm_d, ri_v, ri_s);
        end

        $display("*** SUMMARY: %0d compared / %0d mismatched ***", n_cmp, n_fail);
        $finish;
    end

endmodule
